// File: rtl/icache_pkg.sv
// Shared types and address-field geometry for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  function automatic int offset_bits(input int instr_width);
    return $clog2(instr_width / 8);
  endfunction

  function automatic int word_bits(input int block_width, input int instr_width);
    return $clog2(block_width / instr_width);
  endfunction

  function automatic int index_bits(input int set_count);
    return $clog2(set_count);
  endfunction

  function automatic int word_lsb(input int instr_width);
    return offset_bits(instr_width);
  endfunction

  function automatic int index_lsb(input int block_width, input int instr_width);
    return offset_bits(instr_width) + word_bits(block_width, instr_width);
  endfunction

  function automatic int tag_lsb(input int block_width, input int instr_width, input int set_count);
    return index_lsb(block_width, instr_width) + index_bits(set_count);
  endfunction

  function automatic int way_bits(input int way_count);
    return (way_count > 1) ? $clog2(way_count) : 1;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and data line with combinational hit/word read.
module icache_way
  import icache_pkg::*;
#(
  parameter int SET_COUNT   = 8,
  parameter int INDEX_W     = 3,
  parameter int TAG_W       = 55,
  parameter int BLOCK_WIDTH = 512,
  parameter int INSTR_WIDTH = 32,
  parameter int WORD_W      = 4
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   flush,
  input  logic [INDEX_W-1:0]     index,
  input  logic [TAG_W-1:0]       tag,
  input  logic [WORD_W-1:0]      word,
  input  logic                   fill,
  input  logic [BLOCK_WIDTH-1:0] fill_block,
  output logic                   hit,
  output logic                   line_valid,
  output logic [INSTR_WIDTH-1:0] word_data
);

  logic [SET_COUNT-1:0]   valid_q;
  logic [TAG_W-1:0]       tag_mem  [SET_COUNT];
  logic [BLOCK_WIDTH-1:0] data_mem [SET_COUNT];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[index]  <= tag;
      data_mem[index] <= fill_block;
    end
  end

  assign line_valid = valid_q[index];
  assign hit        = line_valid && (tag_mem[index] == tag);
  assign word_data  = data_mem[index][word*INSTR_WIDTH +: INSTR_WIDTH];

endmodule

// File: rtl/icache_sa.sv
// N-way set-associative instruction cache with miss/refill FSM and round-robin replacement.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_sa
  import icache_pkg::*;
#(
  parameter int WAY_COUNT   = 2,
  parameter int SET_COUNT   = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int BLOCK_WIDTH = 512,
  parameter int ADDR_WIDTH  = 64
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  input  logic                   flush_i,
  output logic [INSTR_WIDTH-1:0] instruction_o,
  output logic                   instr_valid_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic                   mem_resp_valid_i,
  input  logic [BLOCK_WIDTH-1:0] instr_block_i
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]            hit_count_o,
  output logic [31:0]            miss_count_o
`endif
);

  localparam int OFF_W     = offset_bits(INSTR_WIDTH);
  localparam int WORD_W    = word_bits(BLOCK_WIDTH, INSTR_WIDTH);
  localparam int INDEX_W   = index_bits(SET_COUNT);
  localparam int WORD_LSB  = word_lsb(INSTR_WIDTH);
  localparam int INDEX_LSB = index_lsb(BLOCK_WIDTH, INSTR_WIDTH);
  localparam int TAG_LSB   = tag_lsb(BLOCK_WIDTH, INSTR_WIDTH, SET_COUNT);
  localparam int TAG_W     = ADDR_WIDTH - TAG_LSB;
  localparam int WAY_W     = way_bits(WAY_COUNT);

  state_e state;

  logic [TAG_W-1:0]   addr_tag;
  logic [INDEX_W-1:0] addr_index;
  logic [WORD_W-1:0]  addr_word;
  logic [TAG_W-1:0]   miss_tag;
  logic [INDEX_W-1:0] miss_index;
  logic [WORD_W-1:0]  miss_word;
  logic [TAG_W-1:0]   rd_tag;
  logic [INDEX_W-1:0] rd_index;

  logic                   accept;
  logic                   fill_now;
  logic                   hit_any;
  logic [INSTR_WIDTH-1:0] hit_word;
  logic [WAY_W-1:0]       victim;
  logic [WAY_W-1:0]       rr_ptr [SET_COUNT];

  logic [WAY_COUNT-1:0]   way_hit;
  logic [WAY_COUNT-1:0]   way_valid;
  logic [WAY_COUNT-1:0]   way_fill;
  logic [INSTR_WIDTH-1:0] way_word [WAY_COUNT];

  logic [INSTR_WIDTH-1:0] instr_p1;
  logic                   vld_p1;

  logic unused_offset;
  assign unused_offset = ^addr_i[OFF_W-1:0];

  assign addr_tag   = addr_i[ADDR_WIDTH-1:TAG_LSB];
  assign addr_index = addr_i[TAG_LSB-1:INDEX_LSB];
  assign addr_word  = addr_i[INDEX_LSB-1:WORD_LSB];

  // Lookups use the live address in IDLE; the refill path reads the latched miss set.
  assign rd_tag   = (state == IDLE) ? addr_tag   : miss_tag;
  assign rd_index = (state == IDLE) ? addr_index : miss_index;

  assign req_ready_o = (state == IDLE) && !flush_i;
  assign accept      = req_valid_i && req_ready_o;
  assign fill_now    = (state == WAIT) && mem_resp_valid_i;

  for (genvar w = 0; w < WAY_COUNT; w++) begin : g_way
    assign way_fill[w] = fill_now && (victim == WAY_W'(w));

    icache_way #(
      .SET_COUNT  (SET_COUNT),
      .INDEX_W    (INDEX_W),
      .TAG_W      (TAG_W),
      .BLOCK_WIDTH(BLOCK_WIDTH),
      .INSTR_WIDTH(INSTR_WIDTH),
      .WORD_W     (WORD_W)
    ) u_way (
      .clk       (clk_i),
      .arst_n    (arst_ni),
      .flush     (flush_i && (state == IDLE)),
      .index     (rd_index),
      .tag       (rd_tag),
      .word      (addr_word),
      .fill      (way_fill[w]),
      .fill_block(instr_block_i),
      .hit       (way_hit[w]),
      .line_valid(way_valid[w]),
      .word_data (way_word[w])
    );
  end

  always_comb begin
    hit_any  = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAY_COUNT; w++) begin
      if (way_hit[w]) begin
        hit_any  = 1'b1;
        hit_word = way_word[w];
      end
    end
  end

  // Lowest-index invalid way wins; a full set falls back to its round-robin pointer.
  always_comb begin
    logic found;
    found  = 1'b0;
    victim = rr_ptr[rd_index];
    for (int w = 0; w < WAY_COUNT; w++) begin
      if (!found && !way_valid[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  function automatic logic [WAY_W-1:0] ptr_next(input logic [WAY_W-1:0] p);
    return (p == WAY_W'(WAY_COUNT - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state           <= IDLE;
      instr_p1        <= '0;
      vld_p1          <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_addr_o      <= '0;
      miss_tag        <= '0;
      miss_index      <= '0;
      miss_word       <= '0;
      for (int s = 0; s < SET_COUNT; s++) begin
        rr_ptr[s] <= '0;
      end
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (hit_any) begin
              instr_p1 <= hit_word;
              vld_p1   <= 1'b1;
            end else begin
              miss_tag        <= addr_tag;
              miss_index      <= addr_index;
              miss_word       <= addr_word;
              mem_addr_o      <= {addr_i[ADDR_WIDTH-1:INDEX_LSB], {INDEX_LSB{1'b0}}};
              mem_req_valid_o <= 1'b1;
              state           <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid_i) begin
            instr_p1           <= instr_block_i[miss_word*INSTR_WIDTH +: INSTR_WIDTH];
            vld_p1             <= 1'b1;
            rr_ptr[miss_index] <= ptr_next(rr_ptr[miss_index]);
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign instruction_o = instr_p1;
  assign instr_valid_o = vld_p1;

`ifdef ICACHE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else if (accept) begin
      if (hit_any) hit_count_o  <= sat_inc(hit_count_o);
      else         miss_count_o <= sat_inc(miss_count_o);
    end
  end
`endif

endmodule
